// File: rtl/cpu_bus_master.sv
// cpu_bus_master: stands in for the NES console CPU on the cartridge bus.
// It runs M2 continuously and turns a valid/ready request interface into
// 6502-style bus cycles: single writes, or read bursts at incrementing
// addresses. Read data from the mapper comes back as one rsp_valid pulse
// per beat.
//
// Optional feature macro: CPU_BM_OPENBUS_EN
//   defined   : an undriven read returns the last byte seen on the data bus
//   undefined : an undriven read returns FF
module cpu_bus_master #(
  parameter int LO_CYC = 14,
  parameter int HI_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [7:0]  req_len,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        bus_m2,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_dout,
  output logic        bus_doe,
  input  logic [7:0]  bus_din,
  input  logic        bus_din_oe
);

  localparam int PERIOD = LO_CYC + HI_CYC;
  localparam int PH_W   = $clog2(PERIOD);

  // Phase values at which registered outputs are prepared for the next clk.
  localparam logic [PH_W-1:0] LAST_PH     = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PRE_LAST_PH = PH_W'(PERIOD - 2);
  localparam logic [PH_W-1:0] PRE_HI_PH   = PH_W'(LO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  state_t          state;
  logic [PH_W-1:0] ph;
  logic [7:0]      beat;
  logic [7:0]      len_q;
  logic [7:0]      cap_data;

`ifdef CPU_BM_OPENBUS_EN
  // Last byte driven on the data bus by either side; floats back on reads.
  logic [7:0] open_bus;
`endif

  // Byte captured at the end of a read cycle, with open-bus substitution.
  always_comb begin
`ifdef CPU_BM_OPENBUS_EN
    cap_data = bus_din_oe ? bus_din : open_bus;
`else
    cap_data = bus_din_oe ? bus_din : 8'hFF;
`endif
  end

  // Phase counter, M2 generation, bus cycle sequencing and request handshake.
  // NOTE: asynchronous reset puts every output at its idle value at once,
  // without waiting for a clock edge, so a mid-burst reset drops the bus
  // cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ph        <= '0;
      beat      <= '0;
      len_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      busy      <= 1'b0;
      bus_m2    <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_rw    <= 1'b1;
      bus_dout  <= 8'h00;
      bus_doe   <= 1'b0;
`ifdef CPU_BM_OPENBUS_EN
      open_bus  <= 8'h00;
`endif
    end else begin
      // NOTE: all state here uses non-blocking assignments so every test of
      // ph/state/beat below sees the values from before this edge.
      rsp_valid <= 1'b0;
      req_ready <= 1'b0;

      if (ph == LAST_PH) begin
        ph <= '0;
      end else begin
        ph <= ph + 1'b1;
      end

      // Rising M2 half; the master drives data only while M2 is high in a write.
      if (ph == PRE_HI_PH) begin
        bus_m2  <= 1'b1;
        bus_doe <= (state == S_WR);
      end

      // Ready is offered for the boundary clk whenever the current cycle is
      // the last one of the running request.
      if (ph == PRE_LAST_PH) begin
        req_ready <= (state != S_RD) || (beat == len_q);
      end

      // Cycle boundary: finish the current cycle and set up the next one.
      if (ph == LAST_PH) begin
        bus_m2  <= 1'b0;
        bus_doe <= 1'b0;

        if (state == S_RD) begin
          rsp_valid <= 1'b1;
          rsp_data  <= cap_data;
`ifdef CPU_BM_OPENBUS_EN
          open_bus  <= cap_data;
`endif
        end
`ifdef CPU_BM_OPENBUS_EN
        if (state == S_WR) begin
          open_bus <= bus_dout;
        end
`endif

        if (state == S_RD && beat != len_q) begin
          // Next beat of the burst; 16-bit address wraps naturally.
          beat     <= beat + 8'd1;
          bus_addr <= bus_addr + 16'd1;
        end else if (req_ready && req_valid) begin
          state    <= req_rw ? S_RD : S_WR;
          bus_addr <= req_addr;
          bus_rw   <= req_rw;
          if (!req_rw) begin
            bus_dout <= req_wdata;
          end
          len_q    <= req_len;
          beat     <= 8'd0;
          busy     <= 1'b1;
        end else begin
          // Dummy read cycle at the last address.
          state  <= S_IDLE;
          bus_rw <= 1'b1;
          busy   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master with default timing (14 low / 16 high).
// The mapper model returns the address low byte; its output enable is
// controlled per test.
module tb_cpu_bus_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  req_len;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        bus_m2;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_dout;
  logic        bus_doe;
  logic [7:0]  bus_din;
  logic        bus_din_oe;

  int n_checks = 0;
  int n_errors = 0;

  cpu_bus_master #(.LO_CYC(14), .HI_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_len    (req_len),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .bus_m2     (bus_m2),
    .bus_addr   (bus_addr),
    .bus_rw     (bus_rw),
    .bus_dout   (bus_dout),
    .bus_doe    (bus_doe),
    .bus_din    (bus_din),
    .bus_din_oe (bus_din_oe)
  );

  assign bus_din = bus_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background monitors: rsp pulse count, bus stability while M2 high,
  // and data drive outside the M2-high window.
  int          rsp_count = 0;
  int          stab_viol = 0;
  int          doe_viol  = 0;
  logic        prev_m2   = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic        prev_rw   = 1'b1;
  logic [7:0]  prev_dout = 8'h0;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_count++;
    if (prev_m2 && bus_m2 &&
        (bus_addr !== prev_addr || bus_rw !== prev_rw || bus_dout !== prev_dout))
      stab_viol++;
    if (bus_doe === 1'b1 && bus_m2 !== 1'b1) doe_viol++;
    prev_m2   = bus_m2;
    prev_addr = bus_addr;
    prev_rw   = bus_rw;
    prev_dout = bus_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the negedge where req_ready is high (ph = LAST), bounded.
  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("ready_seen", 32'(req_ready), 32'd1);
  endtask

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        din_oe;
    logic [7:0]  exp_data;  // bus_dout for writes, rsp_data for reads
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  logic [7:0]  ob_after_3c;
  logic [7:0]  ob_after_ab;
  logic [15:0] burst_addr [4];
  logic [7:0]  burst_data [4];

  initial begin
    int hi_cnt, rise_cnt, first_hi, rsp_seen, busy_seen, rw_bad, addr_bad;
    int doe_cnt, rc, lows;
    logic pm;

`ifdef CPU_BM_OPENBUS_EN
    ob_after_3c = 8'h3C;
    ob_after_ab = 8'hAB;
`else
    ob_after_3c = 8'hFF;
    ob_after_ab = 8'hFF;
`endif
    vecs[0] = '{rw: 1'b0, addr: 16'h6000, wdata: 8'h5A, din_oe: 1'b1, exp_data: 8'h5A};
    vecs[1] = '{rw: 1'b1, addr: 16'h1234, wdata: 8'h00, din_oe: 1'b1, exp_data: 8'h34};
    vecs[2] = '{rw: 1'b0, addr: 16'h4100, wdata: 8'h3C, din_oe: 1'b1, exp_data: 8'h3C};
    vecs[3] = '{rw: 1'b1, addr: 16'h5000, wdata: 8'h00, din_oe: 1'b0, exp_data: ob_after_3c};
    vecs[4] = '{rw: 1'b1, addr: 16'h00AB, wdata: 8'h00, din_oe: 1'b1, exp_data: 8'hAB};
    vecs[5] = '{rw: 1'b1, addr: 16'h5000, wdata: 8'h00, din_oe: 1'b0, exp_data: ob_after_ab};
    burst_addr[0] = 16'hFFFE; burst_addr[1] = 16'hFFFF;
    burst_addr[2] = 16'h0000; burst_addr[3] = 16'h0001;
    burst_data[0] = 8'hFE; burst_data[1] = 8'hFF;
    burst_data[2] = 8'h00; burst_data[3] = 8'h01;

    rst = 1'b1;
    req_valid = 1'b0; req_rw = 1'b1; req_addr = 16'h0;
    req_wdata = 8'h0; req_len = 8'h0; bus_din_oe = 1'b1;

    // ---------------- reset values ----------------
    step(3);
    check("rst_m2",    32'(bus_m2),    32'd0);
    check("rst_addr",  32'(bus_addr),  32'h0000);
    check("rst_rw",    32'(bus_rw),    32'd1);
    check("rst_dout",  32'(bus_dout),  32'h00);
    check("rst_doe",   32'(bus_doe),   32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rspv",  32'(rsp_valid), 32'd0);
    check("rst_rspd",  32'(rsp_data),  32'h00);
    check("rst_busy",  32'(busy),      32'd0);
    rst = 1'b0;

    // ---------------- idle: 3 M2 cycles ----------------
    hi_cnt = 0; rise_cnt = 0; first_hi = -1; rsp_seen = 0;
    busy_seen = 0; rw_bad = 0; addr_bad = 0; pm = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (bus_m2) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end
      if (bus_m2 && !pm) rise_cnt++;
      pm = bus_m2;
      if (rsp_valid) rsp_seen++;
      if (busy) busy_seen++;
      if (bus_rw !== 1'b1) rw_bad++;
      if (bus_addr !== 16'h0000) addr_bad++;
      @(negedge clk);
    end
    check("idle_hi_clks",  32'(hi_cnt),    32'd48);
    check("idle_rises",    32'(rise_cnt),  32'd3);
    check("idle_first_hi", 32'(first_hi),  32'd14);
    check("idle_rsp",      32'(rsp_seen),  32'd0);
    check("idle_busy",     32'(busy_seen), 32'd0);
    check("idle_rw",       32'(rw_bad),    32'd0);
    check("idle_addr",     32'(addr_bad),  32'd0);

    // ---------------- table: single writes and reads ----------------
    for (int i = 0; i < NV; i++) begin
      wait_ready();
      req_valid  = 1'b1;
      req_rw     = vecs[i].rw;
      req_addr   = vecs[i].addr;
      req_wdata  = vecs[i].wdata;
      req_len    = 8'd5;  // must be ignored for writes; reads use len 0 below
      if (vecs[i].rw) req_len = 8'd0;
      bus_din_oe = vecs[i].din_oe;
      @(negedge clk);  // ph = 0
      req_valid = 1'b0;
      req_addr  = 16'hDEAD;
      req_wdata = 8'hEE;
      req_rw    = ~vecs[i].rw;
      check("vec_addr",  32'(bus_addr),  32'(vecs[i].addr));
      check("vec_rw",    32'(bus_rw),    32'(vecs[i].rw));
      check("vec_busy",  32'(busy),      32'd1);
      check("vec_m2lo",  32'(bus_m2),    32'd0);
      check("vec_rdy0",  32'(req_ready), 32'd0);
      doe_cnt = 0;
      for (int j = 1; j < 30; j++) begin
        @(negedge clk);
        if (bus_doe) doe_cnt++;
        if (j == 14) begin
          check("vec_m2hi", 32'(bus_m2), 32'd1);
          if (!vecs[i].rw) check("vec_dout", 32'(bus_dout), 32'(vecs[i].exp_data));
        end
      end
      // ph = LAST
      check("vec_doe_clks", 32'(doe_cnt),   vecs[i].rw ? 32'd0 : 32'd16);
      check("vec_busy_end", 32'(busy),      32'd1);
      check("vec_rdy_end",  32'(req_ready), 32'd1);
      check("vec_rsp_pre",  32'(rsp_valid), 32'd0);
      @(negedge clk);  // ph = 0 of following dummy cycle
      check("vec_rspv",  32'(rsp_valid), 32'(vecs[i].rw));
      if (vecs[i].rw) check("vec_rspd", 32'(rsp_data), 32'(vecs[i].exp_data));
      check("vec_idle_busy", 32'(busy),   32'd0);
      check("vec_dummy_rw",  32'(bus_rw), 32'd1);
    end

    // ---------------- read burst across FFFF ----------------
    wait_ready();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'hFFFE; req_len = 8'd3;
    bus_din_oe = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rc = rsp_count;
    for (int k = 0; k < 4; k++) begin
      check("burst_addr", 32'(bus_addr), 32'(burst_addr[k]));
      check("burst_busy", 32'(busy), 32'd1);
      check("burst_rspv", 32'(rsp_valid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) check("burst_rspd", 32'(rsp_data), 32'(burst_data[k-1]));
      step(29);
      check("burst_ready", 32'(req_ready), (k == 3) ? 32'd1 : 32'd0);
      step(1);
    end
    check("burst_last_rspv", 32'(rsp_valid), 32'd1);
    check("burst_last_rspd", 32'(rsp_data),  32'h01);
    check("burst_done_busy", 32'(busy),      32'd0);
    step(1);
    check("burst_pulses", 32'(rsp_count - rc), 32'd4);

    // ---------------- back-to-back read then write ----------------
    wait_ready();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h8000; req_len = 8'd0;
    @(negedge clk);
    req_rw = 1'b0; req_addr = 16'h8001; req_wdata = 8'h77;  // valid held
    check("b2b_rd_addr", 32'(bus_addr), 32'h8000);
    check("b2b_rd_rw",   32'(bus_rw),   32'd1);
    step(29);
    check("b2b_ready1", 32'(req_ready), 32'd1);
    check("b2b_busy1",  32'(busy),      32'd1);
    step(1);
    req_valid = 1'b0;
    check("b2b_wr_addr", 32'(bus_addr),  32'h8001);
    check("b2b_wr_rw",   32'(bus_rw),    32'd0);
    check("b2b_rspv",    32'(rsp_valid), 32'd1);
    check("b2b_rspd",    32'(rsp_data),  32'h00);
    check("b2b_busy2",   32'(busy),      32'd1);
    step(14);
    check("b2b_doe",  32'(bus_doe),  32'd1);
    check("b2b_dout", 32'(bus_dout), 32'h77);
    step(15);
    check("b2b_ready2", 32'(req_ready), 32'd1);
    step(1);
    check("b2b_end_busy", 32'(busy),     32'd0);
    check("b2b_end_rw",   32'(bus_rw),   32'd1);
    check("b2b_end_addr", 32'(bus_addr), 32'h8001);

    // ---------------- reset in the middle of a burst ----------------
    wait_ready();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h1000; req_len = 8'd3;
    @(negedge clk);
    req_valid = 1'b0;
    step(60);  // ph = 0 of beat 2
    check("mid_addr", 32'(bus_addr), 32'h1002);
    step(20);  // ph = 20, M2 high
    check("mid_m2", 32'(bus_m2), 32'd1);
    rc = rsp_count;
    rst = 1'b1;
    #1;
    check("mrst_m2",   32'(bus_m2),    32'd0);
    check("mrst_doe",  32'(bus_doe),   32'd0);
    check("mrst_busy", 32'(busy),      32'd0);
    check("mrst_addr", 32'(bus_addr),  32'h0000);
    check("mrst_rw",   32'(bus_rw),    32'd1);
    check("mrst_rspd", 32'(rsp_data),  32'h00);
    step(3);
    rst = 1'b0;
    lows = 0;
    while (bus_m2 !== 1'b1 && lows < 40) begin
      @(negedge clk);
      lows++;
    end
    check("mrst_low_clks", 32'(lows), 32'd14);
    step(100);
    check("mrst_no_rsp", 32'(rsp_count - rc), 32'd0);
    check("mrst_idle",   32'(busy),           32'd0);

    // ---------------- whole-run bus rules ----------------
    check("stable_while_m2", 32'(stab_viol), 32'd0);
    check("doe_only_m2_hi",  32'(doe_viol),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
